// File: rtl/alu_cmd_issuer_pkg.sv
// Shared constants for the alu command issuer: op codes, FSM states and
// the reserved-op test used by both the issuer and its alu.
package alu_cmd_issuer_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND      = 4'd0;
  localparam logic [3:0] OP_OR       = 4'd1;
  localparam logic [3:0] OP_XOR      = 4'd2;
  localparam logic [3:0] OP_NOR      = 4'd3;
  localparam logic [3:0] OP_RESERVED = 4'd4;
  localparam logic [3:0] OP_ADD      = 4'd5;
  localparam logic [3:0] OP_SUB      = 4'd6;
  localparam logic [3:0] OP_SLT      = 4'd7;
  localparam logic [3:0] OP_SRL      = 4'd8;
  localparam logic [3:0] OP_SLL      = 4'd9;
  localparam logic [3:0] OP_SRA      = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 4 and 11..15 carry no operation.
  function automatic logic op_is_reserved(input logic [3:0] op);
    return (op == OP_RESERVED) || (op >= 4'd11);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_alu.sv
// Combinational 32-bit alu: logic ops, add/sub with signed overflow,
// signed set-less-than and shifts by Y[4:0]. Reserved codes give Z=0.
module alu_cmd_issuer_alu
  import alu_cmd_issuer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op_code,
  output logic [WIDTH-1:0] z,
  output logic             equal,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             lt;

  assign sum   = x + y;
  assign diff  = x - y;
  assign shamt = y[SHW-1:0];
  assign lt    = $signed(x) < $signed(y);

  // Result mux and signed-overflow detection for add/sub.
  always_comb begin
    z        = '0;
    overflow = 1'b0;
    case (op_code)
      OP_AND: z = x & y;
      OP_OR:  z = x | y;
      OP_XOR: z = x ^ y;
      OP_NOR: z = ~(x | y);
      OP_ADD: begin
        z        = sum;
        overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        z        = diff;
        overflow = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLT: z = {{(WIDTH-1){1'b0}}, lt};
      OP_SRL: z = x >> shamt;
      OP_SLL: z = x << shamt;
      OP_SRA: z = $signed(x) >>> shamt;
      default: z = '0;
    endcase
  end

  assign equal = (x == y);
  assign zero  = (z == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command issuer: accepts one command at a time, runs it through the alu
// for one cycle, and holds the registered result until it is taken.
// Keeps a chaining accumulator and a saturating overflow counter.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_x,
  input  logic [WIDTH-1:0]     cmd_y,
  input  logic                 cmd_use_acc,
  input  logic                 clear_acc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_equal,
  output logic                 res_zero,
  output logic                 res_ovf,
  output logic                 res_err,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [OVF_CNT_W-1:0] OVF_MAX = {OVF_CNT_W{1'b1}};

  state_t                 state_reg;
  logic                   cmd_ready_reg;
  logic                   res_valid_reg;
  logic [3:0]             op_reg;
  logic [WIDTH-1:0]       x_reg;
  logic [WIDTH-1:0]       y_reg;
  logic [WIDTH-1:0]       acc_reg;
  logic                   clear_pending_reg;
  logic [WIDTH-1:0]       res_data_reg;
  logic                   res_equal_reg;
  logic                   res_zero_reg;
  logic                   res_ovf_reg;
  logic                   res_err_reg;
  logic [OVF_CNT_W-1:0]   ovf_count_reg;

  logic [WIDTH-1:0]       alu_z;
  logic                   alu_equal;
  logic                   alu_zero;
  logic                   alu_ovf;
  logic                   op_reserved;

  alu_cmd_issuer_alu #(.WIDTH(WIDTH)) u_alu (
    .x        (x_reg),
    .y        (y_reg),
    .op_code  (op_reg),
    .z        (alu_z),
    .equal    (alu_equal),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  assign op_reserved = op_is_reserved(op_reg);

  // Control FSM with registered handshake outputs, operand capture,
  // result capture, accumulator and overflow counter.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg         <= ST_IDLE;
      cmd_ready_reg     <= 1'b0;
      res_valid_reg     <= 1'b0;
      op_reg            <= '0;
      x_reg             <= '0;
      y_reg             <= '0;
      acc_reg           <= '0;
      clear_pending_reg <= 1'b0;
      res_data_reg      <= '0;
      res_equal_reg     <= 1'b0;
      res_zero_reg      <= 1'b0;
      res_ovf_reg       <= 1'b0;
      res_err_reg       <= 1'b0;
      ovf_count_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Ready is low in the first cycle out of reset, so nothing is
          // accepted until the handshake is actually advertised.
          if (cmd_ready_reg && cmd_valid) begin
            op_reg        <= cmd_op;
            y_reg         <= cmd_y;
            // A same-cycle clear wins over the stale accumulator.
            x_reg         <= cmd_use_acc ? (clear_acc ? '0 : acc_reg) : cmd_x;
            cmd_ready_reg <= 1'b0;
            state_reg     <= ST_EXEC;
          end else begin
            cmd_ready_reg <= 1'b1;
          end
          if (clear_acc) begin
            acc_reg <= '0;
          end
        end

        ST_EXEC: begin
          if (op_reserved) begin
            res_data_reg  <= '0;
            res_equal_reg <= 1'b0;
            res_zero_reg  <= 1'b0;
            res_ovf_reg   <= 1'b0;
            res_err_reg   <= 1'b1;
          end else begin
            res_data_reg  <= alu_z;
            res_equal_reg <= alu_equal;
            res_zero_reg  <= alu_zero;
            res_ovf_reg   <= alu_ovf;
            res_err_reg   <= 1'b0;
            acc_reg       <= alu_z;
            if (alu_ovf && (ovf_count_reg != OVF_MAX)) begin
              ovf_count_reg <= ovf_count_reg + 1'b1;
            end
          end
          // The accumulator is being written this edge; replay the clear
          // in DONE so it is not lost.
          clear_pending_reg <= clear_acc;
          res_valid_reg     <= 1'b1;
          state_reg         <= ST_DONE;
        end

        ST_DONE: begin
          if (clear_acc || clear_pending_reg) begin
            acc_reg <= '0;
          end
          clear_pending_reg <= 1'b0;
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          cmd_ready_reg <= 1'b0;
          res_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_equal = res_equal_reg;
  assign res_zero  = res_zero_reg;
  assign res_ovf   = res_ovf_reg;
  assign res_err   = res_err_reg;
  assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, hand
// sequences for chaining/clear/backpressure/reset/saturation, and random
// commands checked against a behavioural model.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_x;
  logic [31:0] cmd_y;
  logic        cmd_use_acc;
  logic        clear_acc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_equal;
  logic        res_zero;
  logic        res_ovf;
  logic        res_err;
  logic [7:0]  ovf_count;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  logic [31:0] acc_m;
  int          ovf_m;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(32), .OVF_CNT_W(8)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_use_acc (cmd_use_acc),
    .clear_acc   (clear_acc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_equal   (res_equal),
    .res_zero    (res_zero),
    .res_ovf     (res_ovf),
    .res_err     (res_err),
    .ovf_count   (ovf_count)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] data;
    logic        eq;
    logic        zr;
    logic        ov;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn);
    end
  endtask

  // Behavioural alu: arithmetic done in 64-bit signed integers.
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] z, output logic eq, output logic zr,
                         output logic ov, output logic err);
    longint sx, sy, r;
    int sh;
    sx  = longint'(int'(x));
    sy  = longint'(int'(y));
    sh  = int'(y[4:0]);
    z   = 32'd0;
    ov  = 1'b0;
    err = (op == 4'd4) || (op >= 4'd11);
    case (op)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: z = x ^ y;
      4'd3: z = ~(x | y);
      4'd5: begin r = sx + sy; z = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd6: begin r = sx - sy; z = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd7: z = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: z = 32'(longint'(x) / (longint'(1) << sh));
      4'd9: z = 32'(longint'(x) * (longint'(1) << sh));
      4'd10: z = 32'(int'(x) >>> sh);
      default: z = 32'd0;
    endcase
    eq = !err && (x == y);
    zr = !err && (z == 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) return;
      tick();
    end
    chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  // One full transaction with explicit expectations.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic use_acc, input logic clr, input logic clr_exec, input int hold,
                         input logic [31:0] e_data, input logic e_eq, input logic e_zr,
                         input logic e_ov, input logic e_err, input int e_ovfc);
    logic [31:0] held;
    txn++;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
    cmd_use_acc = use_acc; clear_acc = clr;
    tick();
    cmd_valid = 1'b0; clear_acc = clr_exec;
    chk("exec_res_valid", {31'd0, res_valid}, 32'd0);
    chk("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    clear_acc = 1'b0;
    chk("done_res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_data", res_data, e_data);
    chk("res_flags", {28'd0, res_equal, res_zero, res_ovf, res_err}, {28'd0, e_eq, e_zr, e_ov, e_err});
    chk("ovf_count", {24'd0, ovf_count}, 32'(e_ovfc));
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      cmd_valid = (i == 0);
      cmd_op = 4'd5; cmd_x = 32'h1234; cmd_y = 32'h1;
      tick();
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", res_data, held);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_res_valid", {31'd0, res_valid}, 32'd0);
    chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    $display("txn %0d op=%0d x=%h y=%h use_acc=%0b -> data=%h eq=%0b zero=%0b ovf=%0b err=%0b ovf_count=%0d",
             txn, op, x, y, use_acc, res_data, res_equal, res_zero, res_ovf, res_err, ovf_count);
  endtask

  // Model-driven transaction: expectations come from the reference model.
  task automatic model_cmd(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic use_acc, input logic clr, input logic clr_exec, input int hold);
    logic [31:0] z, xin;
    logic eq, zr, ov, err;
    if (clr) acc_m = 32'd0;
    xin = use_acc ? acc_m : x;
    ref_alu(op, xin, y, z, eq, zr, ov, err);
    if (err) begin z = 32'd0; ov = 1'b0; end
    else acc_m = z;
    if (clr_exec) acc_m = 32'd0;
    if (ov && ovf_m < 255) ovf_m++;
    run_cmd(op, x, y, use_acc, clr, clr_exec, hold, z, eq, zr, ov, err, ovf_m);
  endtask

  initial begin
    rstb = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_use_acc = 1'b0; clear_acc = 1'b0; res_ready = 1'b0;
    acc_m = 32'd0; ovf_m = 0;

    vecs[0]  = '{4'd5,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0};
    vecs[1]  = '{4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0};
    vecs[2]  = '{4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0};
    vecs[3]  = '{4'd1,  32'h0000000A, 32'h00000005, 32'h0000000F, 0, 0, 0, 0};
    vecs[4]  = '{4'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 0, 0, 0};
    vecs[5]  = '{4'd3,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1, 0, 0, 0};
    vecs[6]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0};
    vecs[7]  = '{4'd8,  32'h80000000, 32'h00000004, 32'h08000000, 0, 0, 0, 0};
    vecs[8]  = '{4'd9,  32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 0, 0};
    vecs[9]  = '{4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 0, 0, 0, 0};
    vecs[10] = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 0};
    vecs[11] = '{4'd4,  32'h00000001, 32'h00000001, 32'h00000000, 0, 0, 0, 1};
    vecs[12] = '{4'd13, 32'h00000001, 32'h00000001, 32'h00000000, 0, 0, 0, 1};

    // Reset state.
    tick(); tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    rstb = 1'b1;
    chk("rst_exit_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("first_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].ov && ovf_m < 255) ovf_m++;
      if (!vecs[i].err) acc_m = vecs[i].data;
      run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, 1'b0, 1'b0, 0,
              vecs[i].data, vecs[i].eq, vecs[i].zr, vecs[i].ov, vecs[i].err, ovf_m);
    end
    // Reserved ops left the accumulator at 0x7FFFFFFF.
    run_cmd(4'd5, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h7FFFFFFF, 0, 0, 0, 0, ovf_m);

    // Chaining and clears.
    run_cmd(4'd5, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 0, 32'd7, 0, 0, 0, 0, ovf_m);
    run_cmd(4'd5, 32'hDEAD, 32'd10, 1'b1, 1'b0, 1'b0, 0, 32'd17, 0, 0, 0, 0, ovf_m);
    clear_acc = 1'b1; tick(); clear_acc = 1'b0;
    run_cmd(4'd1, 32'hBEEF, 32'h5, 1'b1, 1'b0, 1'b0, 0, 32'h5, 0, 0, 0, 0, ovf_m);
    run_cmd(4'd5, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'd9, 0, 0, 0, 0, ovf_m);
    run_cmd(4'd5, 32'd100, 32'd2, 1'b1, 1'b1, 1'b0, 0, 32'd2, 0, 0, 0, 0, ovf_m);
    run_cmd(4'd5, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 0, 32'd7, 0, 0, 0, 0, ovf_m);
    run_cmd(4'd5, 32'd50, 32'd1, 1'b1, 1'b0, 1'b0, 0, 32'd1, 0, 0, 0, 0, ovf_m);
    acc_m = 32'd1;

    // Backpressure for 5 cycles with a competing command presented.
    model_cmd(4'd5, 32'd20, 32'd22, 1'b0, 1'b0, 1'b0, 5);

    // Reset during EXEC discards the command and clears state.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_x = 32'd1; cmd_y = 32'd1; cmd_use_acc = 1'b0;
    tick();
    cmd_valid = 1'b0; rstb = 1'b0;
    tick();
    rstb = 1'b1;
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("midrst_ovf_count", {24'd0, ovf_count}, 32'd0);
    chk("midrst_res_data", res_data, 32'd0);
    tick();
    chk("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_no_result", {31'd0, res_valid}, 32'd0);
    acc_m = 32'd0; ovf_m = 0;
    model_cmd(4'd5, 32'hFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 0);

    // Random commands against the model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = ($urandom_range(0, 3) == 0) ? (32'h7FFFFF00 + 32'($urandom_range(0, 255))) : $urandom;
      y  = ($urandom_range(0, 4) == 0) ? x : $urandom;
      model_cmd(op, x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Saturate the overflow counter.
    for (int i = 0; i < 300; i++) begin
      model_cmd(4'd5, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("ovf_saturated", {24'd0, ovf_count}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
